// File: rtl/seq_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Optional leading-zero blanking enabled by defining SEQ_BIN2BCD_BLANK_EN.
module seq_bin2bcd #(
    parameter int unsigned W     = 16,
    parameter int unsigned N_DIG = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [W-1:0]       bin_in,
    output logic [4*N_DIG-1:0] bcd_out,
    output logic               valid,
    output logic               busy,
    output logic               ovf
);

    localparam int unsigned BCD_W  = 4 * N_DIG;
    localparam int unsigned WORK_W = BCD_W + 1;
    localparam int unsigned CNT_W  = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       shreg_q, shreg_d;
    logic [WORK_W-1:0]  work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_work_q, ovf_work_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;

    logic [BCD_W-1:0]   dig_adj;
    logic [WORK_W-1:0]  work_shift;
    logic [W-1:0]       shreg_shift;
    logic [BCD_W-1:0]   bcd_fmt;

    // Add-3 correction on every digit in parallel, then one-bit shift of {work, shreg}
    always_comb begin
        dig_adj = work_q[BCD_W-1:0];
        for (int d = 0; d < int'(N_DIG); d++) begin
            if (work_q[4*d +: 4] >= 4'd5) begin
                dig_adj[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
            end
        end
        work_shift  = {dig_adj, shreg_q[W-1]};
        shreg_shift = {shreg_q[W-2:0], 1'b0};
    end

`ifdef SEQ_BIN2BCD_BLANK_EN
    logic seen_nz;

    // Leading zeros above the top nonzero digit become 4'hF; digit 0 always shown
    always_comb begin
        bcd_fmt = work_q[BCD_W-1:0];
        seen_nz = 1'b0;
        for (int d = int'(N_DIG) - 1; d >= 1; d--) begin
            if (!seen_nz && (bcd_fmt[4*d +: 4] == 4'h0)) begin
                bcd_fmt[4*d +: 4] = 4'hF;
            end else begin
                seen_nz = 1'b1;
            end
        end
    end
`else
    always_comb begin
        bcd_fmt = work_q[BCD_W-1:0];
    end
`endif

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        ovf_work_d = ovf_work_q;
        bcd_d      = bcd_q;
        valid_d    = 1'b0;
        ovf_d      = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d    = bin_in;
                    work_d     = '0;
                    cnt_d      = CNT_W'(W);
                    ovf_work_d = 1'b0;
                    state_d    = S_CONV;
                end
            end
            S_CONV: begin
                shreg_d    = shreg_shift;
                work_d     = work_shift;
                cnt_d      = cnt_q - CNT_W'(1);
                // Spill bit is sticky: it may be shifted out again on a later step
                ovf_work_d = ovf_work_q | work_q[BCD_W];
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bcd_d   = bcd_fmt;
                ovf_d   = ovf_work_q | work_q[BCD_W];
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            ovf_work_q <= 1'b0;
            bcd_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            ovf_work_q <= ovf_work_d;
            bcd_q      <= bcd_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bcd_out = bcd_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Bench for seq_bin2bcd: a 5-digit and a 4-digit instance share stimulus; scoreboard checked on valid.
module tb_seq_bin2bcd;

    localparam int unsigned W = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [W-1:0]  bin_in;
    logic [19:0]   bcd5;
    logic          v5, b5, o5;
    logic [15:0]   bcd4;
    logic          v4, b4, o4;

    always #5 clk = ~clk;

    seq_bin2bcd #(.W(16), .N_DIG(5)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .bin_in(bin_in),
        .bcd_out(bcd5), .valid(v5), .busy(b5), .ovf(o5)
    );

    seq_bin2bcd #(.W(16), .N_DIG(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start), .bin_in(bin_in),
        .bcd_out(bcd4), .valid(v4), .busy(b4), .ovf(o4)
    );

    typedef struct {
        logic [15:0] bin;
        logic [19:0] e5;
        logic        o5;
        logic [15:0] e4;
        logic        o4;
    } vec_t;

    typedef struct {
        logic [19:0] e5;
        logic        o5;
        logic [15:0] e4;
        logic        o4;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [19:0] last5 = '0;
    logic [15:0] last4 = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] blank(input logic [19:0] v, input int nd);
        logic [19:0] r;
        bit          seen;
        r    = v;
        seen = 1'b0;
`ifdef SEQ_BIN2BCD_BLANK_EN
        for (int d = nd - 1; d >= 1; d--) begin
            if (!seen && (r[4*d +: 4] == 4'h0)) r[4*d +: 4] = 4'hF;
            else seen = 1'b1;
        end
`endif
        return r;
    endfunction

    // Plain BCD of val modulo 10^nd
    function automatic logic [19:0] model(input int unsigned val, input int nd);
        logic [19:0]  r;
        int unsigned  x;
        r = '0;
        x = val;
        for (int d = 0; d < nd; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic start_conv(input vec_t v);
        exp_t e;
        e.e5 = blank(v.e5, 5);
        e.o5 = v.o5;
        e.e4 = 16'(blank({4'h0, v.e4}, 4));
        e.o4 = v.o4;
        sb.push_back(e);
        start  = 1'b1;
        bin_in = v.bin;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Called one negedge after the accepting edge; n counts edges since then
    task automatic wait_valid(input string name, input int n0, input int exp_lat);
        int n;
        n = n0;
        while (!v5 && n < 40) begin
            check({name, "_busy"}, 32'(b5), 32'd1);
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, 32'(n), 32'(exp_lat));
        check({name, "_busy_at_valid"}, 32'(b5), 32'd0);
    endtask

    // Scoreboard and hold check
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            last5 = '0;
            last4 = '0;
        end else begin
            check("valid_n4_vs_n5", 32'(v4), 32'(v5));
            if (v5) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_valid: got bcd %h with no pending conversion", bcd5);
                end else begin
                    e = sb.pop_front();
                    check("bcd5", 32'(bcd5), 32'(e.e5));
                    check("ovf5", 32'(o5), 32'(e.o5));
                    check("bcd4", 32'(bcd4), 32'(e.e4));
                    check("ovf4", 32'(o4), 32'(e.o4));
                    last5 = e.e5;
                    last4 = e.e4;
                end
            end else begin
                check("hold5", 32'(bcd5), 32'(last5));
                check("hold4", 32'(bcd4), 32'(last4));
            end
        end
    end

    vec_t tbl[11];
    vec_t rv;

    initial begin
        tbl[0]  = '{16'd0,     20'h00000, 1'b0, 16'h0000, 1'b0};
        tbl[1]  = '{16'd65025, 20'h65025, 1'b0, 16'h5025, 1'b1};
        tbl[2]  = '{16'd65535, 20'h65535, 1'b0, 16'h5535, 1'b1};
        tbl[3]  = '{16'd9999,  20'h09999, 1'b0, 16'h9999, 1'b0};
        tbl[4]  = '{16'd10000, 20'h10000, 1'b0, 16'h0000, 1'b1};
        tbl[5]  = '{16'd1,     20'h00001, 1'b0, 16'h0001, 1'b0};
        tbl[6]  = '{16'd100,   20'h00100, 1'b0, 16'h0100, 1'b0};
        tbl[7]  = '{16'd1234,  20'h01234, 1'b0, 16'h1234, 1'b0};
        tbl[8]  = '{16'd42,    20'h00042, 1'b0, 16'h0042, 1'b0};
        tbl[9]  = '{16'd999,   20'h00999, 1'b0, 16'h0999, 1'b0};
        tbl[10] = '{16'd500,   20'h00500, 1'b0, 16'h0500, 1'b0};

        reset_n = 1'b0;
        start   = 1'b0;
        bin_in  = '0;
        repeat (2) @(negedge clk);
        check("rst_bcd", 32'(bcd5), 32'd0);
        check("rst_valid", 32'(v5), 32'd0);
        check("rst_busy", 32'(b5), 32'd0);
        check("rst_ovf", 32'(o5), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Table vectors, each started on the previous valid cycle
        for (int i = 0; i < 7; i++) begin
            start_conv(tbl[i]);
            wait_valid($sformatf("tbl%0d", i), 0, 17);
        end

        // Random values through the arithmetic model
        for (int i = 0; i < 6; i++) begin
            int unsigned r;
            r      = $urandom_range(0, 65535);
            rv.bin = 16'(r);
            rv.e5  = model(r, 5);
            rv.o5  = 1'b0;
            rv.e4  = 16'(model(r, 4));
            rv.o4  = (r >= 10000);
            start_conv(rv);
            wait_valid($sformatf("rnd%0d", i), 0, 17);
        end
        repeat (3) @(negedge clk);

        // 1234 then 42 started on the valid cycle: 18 clocks between valids
        start_conv(tbl[7]);
        wait_valid("b2b_first", 0, 17);
        start_conv(tbl[8]);
        wait_valid("b2b_second", 0, 17);
        repeat (2) @(negedge clk);

        // start during CONV cycle 5 is ignored
        start_conv(tbl[9]);
        repeat (4) @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd7;
        @(negedge clk);
        start  = 1'b0;
        wait_valid("ignored_start", 5, 17);
        repeat (20) @(negedge clk);
        check("ignored_start_no_extra", 32'(sb.size()), 32'd0);

        // Async reset in the middle of a conversion
        start_conv(tbl[10]);
        wait_valid("pre_reset", 0, 17);
        @(negedge clk);
        rv = '{16'd777, 20'h00777, 1'b0, 16'h0777, 1'b0};
        start_conv(rv);
        repeat (7) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_bcd5", 32'(bcd5), 32'd0);
        check("arst_valid5", 32'(v5), 32'd0);
        check("arst_busy5", 32'(b5), 32'd0);
        check("arst_ovf5", 32'(o5), 32'd0);
        check("arst_bcd4", 32'(bcd4), 32'd0);
        check("arst_busy4", 32'(b4), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rv = '{16'd31, 20'h00031, 1'b0, 16'h0031, 1'b0};
        start_conv(rv);
        wait_valid("post_reset", 0, 17);
        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
